// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - single-address I2C target: write byte strobes, read byte handshake, optional SCL stretch
module i2c_target #(
  parameter logic [6:0] ADDRESS       = 7'h50,
  parameter int         SYNC_STAGES   = 2,
  parameter bit         CLOCK_STRETCH = 1'b1
) (
  input  logic       clk_in,
  input  logic       reset,
  inout  wire        scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_TX_LOAD,
    ST_READ,
    ST_READ_ACK,
    ST_IGNORE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_dly_q, scl_dly_d;
  logic                   sda_dly_q, sda_dly_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   bits_done_q, bits_done_d;
  logic [7:0]             shift_q, shift_d;
  logic [6:0]             tx_shift_q, tx_shift_d;
  logic                   rw_q, rw_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   scl_oe_q, scl_oe_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   busy_q, busy_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall;
  logic start_det, stop_det;

  assign scl = scl_oe_q ? 1'b0 : 1'bz;
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_dly_q;
  assign scl_fall = ~scl_s & scl_dly_q;
  // scl must be high on both samples so an sda change coinciding with an scl rise is not a condition
  assign start_det = ~sda_s & sda_dly_q & scl_s & scl_dly_q;
  assign stop_det  = sda_s & ~sda_dly_q & scl_s & scl_dly_q;

  assign tx_ready = (state_q == ST_TX_LOAD) && !start_det && !stop_det;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

  always_comb begin
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_dly_d   = scl_s;
    sda_dly_d   = sda_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bits_done_d = bits_done_q;
    shift_d     = shift_q;
    tx_shift_d  = tx_shift_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    scl_oe_d    = scl_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    busy_d      = busy_q;

    if (start_det) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd0;
      bits_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      scl_oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      bits_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      scl_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_IGNORE: begin
          sda_oe_d = 1'b0;
          scl_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
        ST_ADDR, ST_WRITE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) bits_done_d = 1'b1;
          end else if (scl_fall && bits_done_q) begin
            bits_done_d = 1'b0;
            if (state_q == ST_WRITE) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = ST_WRITE_ACK;
            end else if (shift_q[7:1] == ADDRESS) begin
              rw_d     = shift_q[0];
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = ST_ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = rw_q ? ST_TX_LOAD : ST_WRITE;
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_WRITE;
          end
        end
        ST_TX_LOAD: begin
          if (tx_valid && tx_ready) begin
            tx_shift_d = tx_data[6:0];
            sda_oe_d   = ~tx_data[7];
            scl_oe_d   = 1'b0;
            bit_cnt_d  = 3'd0;
            state_d    = ST_READ;
          end else if (CLOCK_STRETCH) begin
            scl_oe_d = 1'b1;
          end else if (scl_fall) begin
            // MSB of 8'hFF already went out released; this fall starts bit 6
            tx_shift_d = 7'h7E;
            sda_oe_d   = 1'b0;
            bit_cnt_d  = 3'd1;
            state_d    = ST_READ;
          end
        end
        ST_READ: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = ST_READ_ACK;
            end else begin
              sda_oe_d   = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 3'd1;
            end
          end
        end
        ST_READ_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              busy_d  = 1'b0;
              state_d = ST_IGNORE;
            end
          end else if (scl_fall) begin
            state_d = ST_TX_LOAD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_dly_q   <= 1'b1;
      sda_dly_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      bits_done_q <= 1'b0;
      shift_q     <= 8'h00;
      tx_shift_q  <= 7'h00;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_dly_q   <= scl_dly_d;
      sda_dly_q   <= sda_dly_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bits_done_q <= bits_done_d;
      shift_q     <= shift_d;
      tx_shift_q  <= tx_shift_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      scl_oe_q    <= scl_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule
